// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
interface seq_divider_if #(
  parameter int unsigned N = 4
);
  logic             start;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic [2*N-1:0]   quotient;
  logic [N-1:0]     remainder;
  logic             busy;
  logic             done;
  logic             dbz;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, dbz
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock, MSB first.
module seq_divider #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);
  localparam int unsigned CW = $clog2(2 * N + 1);
  localparam logic [CW-1:0] LAST = CW'(2 * N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [2*N-1:0] shreg;
  logic [N-1:0]   dvsr;
  logic [N:0]     prem;
  logic [CW-1:0]  cnt;
  logic           dbz_pend;

  logic [N:0]     trial;
  logic [N:0]     next_rem;
  logic           qbit;

  // The dividend register shifts out its MSB while quotient bits fill in from the LSB.
  always_comb begin
    trial    = {prem[N-1:0], shreg[2*N-1]};
    qbit     = (trial >= {1'b0, dvsr});
    next_rem = qbit ? (trial - {1'b0, dvsr}) : trial;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      shreg         <= '0;
      dvsr          <= '0;
      prem          <= '0;
      cnt           <= '0;
      dbz_pend      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            shreg    <= bus.dividend;
            dvsr     <= bus.divisor;
            prem     <= '0;
            cnt      <= '0;
            dbz_pend <= (bus.divisor == '0);
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          shreg <= {shreg[2*N-2:0], qbit};
          prem  <= next_rem;
          cnt   <= cnt + 1'b1;
          // A zero divisor always "fits", giving all-ones and passing the low dividend bits through.
          if (cnt == LAST) begin
            bus.quotient  <= {shreg[2*N-2:0], qbit};
            bus.remainder <= next_rem[N-1:0];
            bus.dbz       <= dbz_pend;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            state         <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (N=4): directed cases, random cases, exhaustive back-to-back sweep.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;
  int   last_done_cyc = -1;
  logic [7:0] prev_q = '0;
  logic [3:0] prev_r = '0;
  logic       prev_z = 1'b0;

  seq_divider_if #(.N(4)) bus ();
  seq_divider #(.N(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  task automatic ref_div(input int dvd, input int dvs,
                         output logic [7:0] q, output logic [3:0] r, output logic z);
    if (dvs == 0) begin
      q = 8'hFF;
      r = 4'(dvd % 16);
      z = 1'b1;
    end else begin
      q = 8'(dvd / dvs);
      r = 4'(dvd % dvs);
      z = 1'b0;
    end
  endtask

  // Issues start now; returns right after the edge on which done is observed.
  task automatic op(input int dvd, input int dvs, input bit b2b);
    logic [7:0] eq;
    logic [3:0] er;
    logic       ez;
    int         lat;
    ref_div(dvd, dvs, eq, er, ez);
    bus.dividend = 8'(dvd);
    bus.divisor  = 4'(dvs);
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.dividend = 8'($urandom);
    bus.divisor  = 4'($urandom);
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    check("done_after_accept", 32'(bus.done), 32'd0);
    check("quotient_held", 32'(bus.quotient), 32'(prev_q));
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.done && lat < 40);
    check("latency", lat, 8);
    check("busy_with_done", 32'(bus.busy), 32'd0);
    check("quotient", 32'(bus.quotient), 32'(eq));
    check("remainder", 32'(bus.remainder), 32'(er));
    check("dbz", 32'(bus.dbz), 32'(ez));
    if (b2b && last_done_cyc >= 0) check("done_interval", cyc - last_done_cyc, 9);
    last_done_cyc = cyc;
    prev_q = eq;
    prev_r = er;
    prev_z = ez;
  endtask

  initial begin
    int k;
    int lat;
    int done_seen;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_dbz", 32'(bus.dbz), 32'd0);
    tick();
    tick();
    @(negedge clk) rst = 1'b0;
    tick();

    // Directed cases from the plan.
    op(200, 7, 0);
    tick();
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("result_holds", 32'(bus.quotient), 32'd28);
    op(255, 1, 0);
    tick();
    op(7, 9, 0);
    tick();
    op(0, 5, 0);
    tick();
    op(100, 0, 0);
    tick();
    check("dbz_holds", 32'(bus.dbz), 32'd1);
    op(100, 10, 0);
    tick();

    // Starts while running are ignored.
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    bus.start    = 1'b1;
    tick();
    lat = 0;
    for (k = 1; k <= 12 && !bus.done; k++) begin
      bus.start    = (k == 3 || k == 5);
      bus.dividend = 8'd50;
      bus.divisor  = 4'd3;
      tick();
      lat = k;
    end
    bus.start = 1'b0;
    check("ignore_latency", lat, 8);
    check("ignore_quotient", 32'(bus.quotient), 32'd28);
    check("ignore_remainder", 32'(bus.remainder), 32'd4);
    tick();
    check("ignore_no_rerun", 32'(bus.busy), 32'd0);
    prev_q = 8'd28;
    prev_r = 4'd4;
    prev_z = 1'b0;

    // Reset mid-run aborts without a done pulse.
    op(7, 2, 0);
    tick();
    bus.dividend = 8'd200;
    bus.divisor  = 4'd7;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("abort_quotient", 32'(bus.quotient), 32'd0);
    check("abort_remainder", 32'(bus.remainder), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_dbz", 32'(bus.dbz), 32'd0);
    tick();
    tick();
    @(negedge clk) rst = 1'b0;
    done_seen = 0;
    for (k = 0; k < 12; k++) begin
      tick();
      if (bus.done || bus.busy) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    prev_q = '0;
    prev_r = '0;
    prev_z = 1'b0;
    op(15, 15, 0);
    tick();

    // Random operands, including occasional zero divisors.
    for (int i = 0; i < 40; i++) begin
      op(int'($urandom_range(255, 0)), int'($urandom_range(15, 0)), 0);
      tick();
    end

    // Exhaustive sweep, each start issued on the done cycle of the previous division.
    last_done_cyc = -1;
    for (int dv = 0; dv < 256; dv++) begin
      for (int ds = 0; ds < 16; ds++) begin
        op(dv, ds, 1);
      end
    end
    tick();
    check("final_done_low", 32'(bus.done), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential restoring divider: the inverse of the team's 4x4 array multiplier. It takes a 2N-bit dividend and an N-bit divisor and produces a 2N-bit quotient and an N-bit remainder. It resolves one quotient bit per clock through a shift-subtract datapath under a start/busy/done handshake. It sits beside the multiplier in the arithmetic section and reuses the same operand widths, so a product can be fed straight back for checking.

## Interface
- N, default 4: divisor and remainder width; dividend and quotient are 2N bits.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high; clears all state and outputs.
- start  input  1  request pulse; sampled on rising edge of clk.
- dividend  input  2N  numerator; sampled only on the edge that accepts start.
- divisor  input  N  denominator; sampled only on the edge that accepts start.
- quotient  output  2N  result quotient; registered.
- remainder  output  N  result remainder; registered.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse when results update.
- dbz  output  1  divide-by-zero flag for the last completed division; registered.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE or DONE, start=1: latch dividend into the shift register and divisor into the divisor register. Clear the partial remainder (N+1 bits internal) and the bit counter. Latch dbz_pending = (divisor==0). Go to RUN.
- IDLE or DONE, start=0: go to or stay in IDLE.
- RUN, one iteration per edge, MSB first:
  - trial = {partial_rem[N-1:0], dividend_msb}, where dividend_msb is the current MSB of the dividend shift register.
  - If trial >= {1'b0, divisor}, then partial_rem = trial - divisor and the quotient bit is 1.
  - Otherwise partial_rem = trial and the quotient bit is 0.
  - Shift the quotient bit into the LSB of the dividend/quotient shift register.
- After the 2N-th iteration:
  - Load quotient and remainder outputs and set dbz from dbz_pending.
  - Assert done and go to DONE.
- Divide-by-zero: the iterations still run the full 2N cycles, so latency is fixed. At completion, quotient = all ones and remainder = dividend[N-1:0] (the original operand), and dbz=1. For a nonzero divisor, dbz=0.
- Arithmetic invariant when the divisor is nonzero: dividend == quotient*divisor + remainder, with remainder < divisor. Quotient never overflows 2N bits.
- start in RUN is ignored, and operand inputs are don't-care while busy.
- quotient, remainder and dbz hold their values until the next completion; accepting a new start does not clear them.

## Timing
- Reset values: quotient=0, remainder=0, busy=0, done=0, dbz=0, state IDLE. Reset acts immediately, without waiting for a clock edge.
- Edge E0 samples start=1 in IDLE/DONE. From then, busy=1 and done=0.
- Edges E1..E2N perform the iterations. At E2N, outputs update, done=1 and busy=0.
- Latency is 2N cycles from the accept edge to results valid (8 for N=4).
- done is high for exactly one cycle, between E2N and E2N+1.
- Back-to-back: if start=1 at E2N+1 (state DONE), it is accepted. busy rises and done falls on the same edge, so there is no idle cycle.
- Throughput is one division per 2N+1 cycles when back-to-back.
- Reset asserted mid-RUN aborts the operation. All outputs return to reset values and no done pulse is produced. After deassertion, the first start is accepted normally.
- busy and done are never high in the same cycle.

## Test plan
- N=4, 200/7 -> after 8 cycles done=1, quotient=28, remainder=4, dbz=0; busy high for exactly 8 cycles.
- 255/1 -> quotient=255, remainder=0. 7/9 -> quotient=0, remainder=7. 0/5 -> quotient=0, remainder=0.
- 100/0 -> quotient=8'hFF, remainder=4, dbz=1. A following 100/10 -> quotient=10, remainder=0, dbz=0.
- Start 200/7, then pulse start with 50/3 at cycles 3 and 5 -> both ignored; the single result is 28 r 4.
- Start 200/7, assert rst at cycle 4 -> outputs immediately 0, no done pulse. After release, 15/15 -> quotient=1, remainder=0.
- Back-to-back start on every done cycle over all 4096 (dividend, divisor) pairs -> every result matches the reference division and the dbz rule. The interval between done pulses is 9 cycles.
